// File: rtl/dispatch_pkg.sv
// Shared constants and helpers for the rename/dispatch stage.
// Width-dependent types live in the modules because their widths come from parameters.
package dispatch_pkg;

    typedef logic [4:0] areg_t;

    localparam areg_t       ZERO_REG = 5'd31;
    localparam int unsigned NO_TAG   = 0;

    // Keeps the select field at least one bit wide for a single-RS build.
    function automatic int unsigned sel_width(input int unsigned num_rs);
        return (num_rs > 1) ? $clog2(num_rs) : 1;
    endfunction

endpackage

// File: rtl/dispatch_stage_if.sv
// Upstream uop handshake plus the shared reservation-station write bus.
interface dispatch_stage_if #(
    parameter int unsigned ROB_SIZE = 32,
    parameter int unsigned NUM_RS   = 4,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned CMD_W    = 10
);
    import dispatch_pkg::*;

    localparam int unsigned TAG_W = $clog2(ROB_SIZE + 1);
    localparam int unsigned SEL_W = sel_width(NUM_RS);

    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_rs_sel;
    areg_t             in_rd;
    areg_t             in_rn;
    areg_t             in_rm;
    logic [DATA_W-1:0] in_imm;
    logic              in_use_imm;
    logic              in_reg_write;
    logic [CMD_W-1:0]  in_cmd;

    logic [NUM_RS-1:0] rs_we;
    logic [NUM_RS-1:0] rs_full;
    logic [TAG_W-1:0]  rs_tag;
    logic [TAG_W-1:0]  rs_tag1;
    logic [TAG_W-1:0]  rs_tag2;
    logic [DATA_W-1:0] rs_val1;
    logic [DATA_W-1:0] rs_val2;
    logic [CMD_W-1:0]  rs_cmd;

    modport master (
        output in_valid, in_rs_sel, in_rd, in_rn, in_rm, in_imm, in_use_imm, in_reg_write,
        output in_cmd, rs_full,
        input  in_ready, rs_we, rs_tag, rs_tag1, rs_tag2, rs_val1, rs_val2, rs_cmd
    );

    modport slave (
        input  in_valid, in_rs_sel, in_rd, in_rn, in_rm, in_imm, in_use_imm, in_reg_write,
        input  in_cmd, rs_full,
        output in_ready, rs_we, rs_tag, rs_tag1, rs_tag2, rs_val1, rs_val2, rs_cmd
    );

endinterface

// File: rtl/operand_resolve.sv
// Resolves one source operand to a value or a pending ROB tag.
// Also used on held operands: tag 0 then passes rf_data_i (the held value) straight through.
module operand_resolve
    import dispatch_pkg::*;
#(
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 64
) (
    input  areg_t             areg_i,
    input  logic [TAG_W-1:0]  map_tag_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic [DATA_W:0]   rob_data_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    output logic [TAG_W-1:0]  tag_o,
    output logic [DATA_W-1:0] val_o
);

    always_comb begin
        tag_o = '0;
        val_o = '0;
        if (areg_i != ZERO_REG) begin
            if (map_tag_i == TAG_W'(NO_TAG)) begin
                val_o = rf_data_i;
            end else if (rob_data_i[DATA_W]) begin
                val_o = rob_data_i[DATA_W-1:0];
            end else if (cdb_valid_i && (cdb_tag_i == map_tag_i)) begin
                val_o = cdb_data_i;
            end else begin
                tag_o = map_tag_i;
            end
        end
    end

endmodule

// File: rtl/dispatch_stage.sv
// Rename/dispatch stage: renames a uop, allocates a ROB entry and holds the resolved uop
// in a one-entry register, snooping the CDB, until its reservation station accepts it.
module dispatch_stage
    import dispatch_pkg::*;
#(
    parameter int unsigned ROB_SIZE = 32,
    parameter int unsigned NUM_RS   = 4,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned CMD_W    = 10,
    localparam int unsigned TAG_W   = $clog2(ROB_SIZE + 1),
    localparam int unsigned SEL_W   = sel_width(NUM_RS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    dispatch_stage_if.slave   bus,
    output areg_t             map_raddr1_o,
    output areg_t             map_raddr2_o,
    input  logic [TAG_W-1:0]  map_rdata1_i,
    input  logic [TAG_W-1:0]  map_rdata2_i,
    output logic              map_we_o,
    output areg_t             map_waddr_o,
    output logic [TAG_W-1:0]  map_wdata_o,
    output areg_t             rf_raddr1_o,
    output areg_t             rf_raddr2_o,
    input  logic [DATA_W-1:0] rf_rdata1_i,
    input  logic [DATA_W-1:0] rf_rdata2_i,
    output logic [TAG_W-1:0]  rob_raddr1_o,
    output logic [TAG_W-1:0]  rob_raddr2_o,
    input  logic [DATA_W:0]   rob_rdata1_i,
    input  logic [DATA_W:0]   rob_rdata2_i,
    input  logic [TAG_W-1:0]  rob_tail_i,
    input  logic              rob_full_i,
    output logic              rob_alloc_o,
    output areg_t             rob_alloc_rd_o,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    output logic [31:0]       stall_cycles_o
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } operand_t;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        areg_t             rd;
        areg_t             rn;
        areg_t             rm;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic              reg_write;
        logic [CMD_W-1:0]  cmd;
    } dispatch_uop_t;

    dispatch_uop_t     uop;
    logic              d_valid_q, d_valid_d;
    logic [TAG_W-1:0]  d_tag_q, d_tag_d;
    logic [SEL_W-1:0]  d_sel_q, d_sel_d;
    logic [CMD_W-1:0]  d_cmd_q, d_cmd_d;
    operand_t          d_op1_q, d_op1_d;
    operand_t          d_op2_q, d_op2_d;
    logic [31:0]       stall_q, stall_d;
    logic              d_fire;
    logic              in_ready;
    logic              accept;
    logic [TAG_W-1:0]  acc1_tag, acc2_tag, snp1_tag, snp2_tag;
    logic [DATA_W-1:0] acc1_val, acc2_val, snp1_val, snp2_val;

    always_comb begin
        uop.sel       = bus.in_rs_sel;
        uop.rd        = bus.in_rd;
        uop.rn        = bus.in_rn;
        uop.rm        = bus.in_rm;
        uop.imm       = bus.in_imm;
        uop.use_imm   = bus.in_use_imm;
        uop.reg_write = bus.in_reg_write;
        uop.cmd       = bus.in_cmd;
    end

    operand_resolve #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_acc1 (
        .areg_i     (uop.rn),
        .map_tag_i  (map_rdata1_i),
        .rf_data_i  (rf_rdata1_i),
        .rob_data_i (rob_rdata1_i),
        .cdb_valid_i(cdb_valid_i),
        .cdb_tag_i  (cdb_tag_i),
        .cdb_data_i (cdb_data_i),
        .tag_o      (acc1_tag),
        .val_o      (acc1_val)
    );

    operand_resolve #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_acc2 (
        .areg_i     (uop.rm),
        .map_tag_i  (map_rdata2_i),
        .rf_data_i  (rf_rdata2_i),
        .rob_data_i (rob_rdata2_i),
        .cdb_valid_i(cdb_valid_i),
        .cdb_tag_i  (cdb_tag_i),
        .cdb_data_i (cdb_data_i),
        .tag_o      (acc2_tag),
        .val_o      (acc2_val)
    );

    // Held-operand snoop: never register 31, never ROB-done, so only the CDB match applies.
    operand_resolve #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_snp1 (
        .areg_i     (5'd0),
        .map_tag_i  (d_op1_q.tag),
        .rf_data_i  (d_op1_q.val),
        .rob_data_i ('0),
        .cdb_valid_i(cdb_valid_i),
        .cdb_tag_i  (cdb_tag_i),
        .cdb_data_i (cdb_data_i),
        .tag_o      (snp1_tag),
        .val_o      (snp1_val)
    );

    operand_resolve #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_snp2 (
        .areg_i     (5'd0),
        .map_tag_i  (d_op2_q.tag),
        .rf_data_i  (d_op2_q.val),
        .rob_data_i ('0),
        .cdb_valid_i(cdb_valid_i),
        .cdb_tag_i  (cdb_tag_i),
        .cdb_data_i (cdb_data_i),
        .tag_o      (snp2_tag),
        .val_o      (snp2_val)
    );

    always_comb begin
        d_fire   = d_valid_q & ~bus.rs_full[d_sel_q];
        in_ready = reset_i & ~flush_i & ~rob_full_i & (~d_valid_q | d_fire);
        accept   = bus.in_valid & in_ready;
    end

    always_comb begin
        bus.in_ready   = in_ready;
        map_raddr1_o   = uop.rn;
        map_raddr2_o   = uop.rm;
        rf_raddr1_o    = uop.rn;
        rf_raddr2_o    = uop.rm;
        rob_raddr1_o   = map_rdata1_i;
        rob_raddr2_o   = map_rdata2_i;
        map_we_o       = accept & uop.reg_write & (uop.rd != ZERO_REG);
        map_waddr_o    = uop.rd;
        map_wdata_o    = rob_tail_i;
        rob_alloc_o    = accept;
        rob_alloc_rd_o = uop.rd;
        stall_cycles_o = stall_q;

        bus.rs_we   = '0;
        bus.rs_tag  = '0;
        bus.rs_tag1 = '0;
        bus.rs_tag2 = '0;
        bus.rs_val1 = '0;
        bus.rs_val2 = '0;
        bus.rs_cmd  = '0;
        if (d_valid_q) begin
            bus.rs_tag  = d_tag_q;
            bus.rs_tag1 = snp1_tag;
            bus.rs_tag2 = snp2_tag;
            bus.rs_val1 = snp1_val;
            bus.rs_val2 = snp2_val;
            bus.rs_cmd  = d_cmd_q;
        end
        if (d_fire && !flush_i) begin
            bus.rs_we[d_sel_q] = 1'b1;
        end
    end

    always_comb begin
        d_valid_d = d_valid_q & ~d_fire;
        d_tag_d   = d_tag_q;
        d_sel_d   = d_sel_q;
        d_cmd_d   = d_cmd_q;
        d_op1_d   = '{tag: snp1_tag, val: snp1_val};
        d_op2_d   = '{tag: snp2_tag, val: snp2_val};
        if (accept) begin
            d_valid_d = 1'b1;
            d_tag_d   = rob_tail_i;
            d_sel_d   = uop.sel;
            d_cmd_d   = uop.cmd;
            d_op1_d   = '{tag: acc1_tag, val: acc1_val};
            d_op2_d   = uop.use_imm ? '{tag: '0, val: uop.imm}
                                    : '{tag: acc2_tag, val: acc2_val};
        end
        if (flush_i) begin
            d_valid_d = 1'b0;
        end

        stall_d = stall_q;
        if (bus.in_valid && !in_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            d_valid_q <= 1'b0;
            d_tag_q   <= '0;
            d_sel_q   <= '0;
            d_cmd_q   <= '0;
            d_op1_q   <= '0;
            d_op2_q   <= '0;
            stall_q   <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            d_tag_q   <= d_tag_d;
            d_sel_q   <= d_sel_d;
            d_cmd_q   <= d_cmd_d;
            d_op1_q   <= d_op1_d;
            d_op2_q   <= d_op2_d;
            stall_q   <= stall_d;
        end
    end

endmodule
